// File: rtl/int2frac_if.sv
// Request/result bundle for the decimal-fraction to binary-fraction converter.
// The master drives the operands and start; the slave returns the result and status.
interface int2frac_if #(
    parameter int unsigned ITER  = 16,
    parameter int unsigned DEC_W = 32
);
    logic             int2frac_start;
    logic [DEC_W-1:0] frac_digits;
    logic [3:0]       frac_len;
    logic [ITER-1:0]  frac_part;
    logic             int2frac_done;
    logic             int2frac_busy;
    logic             int2frac_err;

    modport master (
        output int2frac_start,
        output frac_digits,
        output frac_len,
        input  frac_part,
        input  int2frac_done,
        input  int2frac_busy,
        input  int2frac_err
    );

    modport slave (
        input  int2frac_start,
        input  frac_digits,
        input  frac_len,
        output frac_part,
        output int2frac_done,
        output int2frac_busy,
        output int2frac_err
    );
endinterface

// File: rtl/int2frac.sv
// Decimal fraction digits -> 16-bit binary fraction. Scales to a 10^9 fixed-point value,
// extracts bits by repeated doubling against 10^9, then rounds half up with saturation.
module int2frac #(
    parameter int unsigned ITER  = 16,
    parameter int unsigned DEC_W = 32
) (
    input logic        clk,
    input logic        rst,
    int2frac_if.slave  cvt
);

    localparam int unsigned CntW    = $clog2(ITER);
    localparam logic [30:0] Billion = 31'd1_000_000_000;

    typedef enum logic [1:0] {StIdle, StScale, StConv, StRound} state_e;

    state_e          state_q, state_d;
    logic [30:0]     acc_q, acc_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [CntW-1:0] bit_q, bit_d;
    logic [ITER-1:0] res_q, res_d;
    logic [ITER-1:0] frac_q, frac_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [30:0]      twice;
    logic             twice_ge;
    logic [DEC_W-1:0] limit;
    logic             illegal;

    // Upper bound (exclusive) of digits for a given count; lengths above 9 are
    // rejected separately, so their entry here is never relied upon.
    always_comb begin
        unique case (cvt.frac_len)
            4'd0:    limit = DEC_W'(32'd1);
            4'd1:    limit = DEC_W'(32'd10);
            4'd2:    limit = DEC_W'(32'd100);
            4'd3:    limit = DEC_W'(32'd1_000);
            4'd4:    limit = DEC_W'(32'd10_000);
            4'd5:    limit = DEC_W'(32'd100_000);
            4'd6:    limit = DEC_W'(32'd1_000_000);
            4'd7:    limit = DEC_W'(32'd10_000_000);
            4'd8:    limit = DEC_W'(32'd100_000_000);
            4'd9:    limit = DEC_W'(32'd1_000_000_000);
            default: limit = '0;
        endcase
    end

    assign illegal  = (cvt.frac_len > 4'd9) || (cvt.frac_digits >= limit);
    // acc < 10^9 < 2^30 after scaling, so the doubling never overflows 31 bits.
    assign twice    = {acc_q[29:0], 1'b0};
    assign twice_ge = (twice >= Billion);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        res_d   = res_q;
        frac_d  = frac_q;
        done_d  = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (cvt.int2frac_start) begin
                    err_d = 1'b0;
                    if (illegal) begin
                        frac_d = '0;
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        acc_d   = cvt.frac_digits[30:0];
                        cnt_d   = cvt.frac_len;
                        bit_d   = '0;
                        res_d   = '0;
                        state_d = (cvt.frac_len == 4'd9) ? StConv : StScale;
                    end
                end
            end

            StScale: begin
                acc_d = (acc_q << 3) + (acc_q << 1);
                cnt_d = cnt_q + 4'd1;
                if (cnt_q + 4'd1 == 4'd9) begin
                    state_d = StConv;
                end
            end

            StConv: begin
                if (twice_ge) begin
                    res_d = {res_q[ITER-2:0], 1'b1};
                    acc_d = twice - Billion;
                end else begin
                    res_d = {res_q[ITER-2:0], 1'b0};
                    acc_d = twice;
                end
                bit_d = bit_q + CntW'(1);
                if (bit_q == CntW'(ITER - 1)) begin
                    state_d = StRound;
                end
            end

            StRound: begin
                // Round half up, but never wrap an all-ones result back to zero.
                if (twice_ge && !(&res_q)) begin
                    frac_d = res_q + ITER'(1);
                end else begin
                    frac_d = res_q;
                end
                done_d  = 1'b1;
                err_d   = 1'b0;
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            res_q   <= '0;
            frac_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            res_q   <= res_d;
            frac_q  <= frac_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cvt.frac_part     = frac_q;
    assign cvt.int2frac_done = done_q;
    assign cvt.int2frac_err  = err_q;
    assign cvt.int2frac_busy = (state_q != StIdle);

endmodule
